color_proc_sched: RTL and testbench
===================================

# color_proc_sched

Frame-level scheduler that sequences the colour-processing datapath between the original and processed frame buffers. After each completed capture frame it sweeps every pixel address of the original buffer's read port. It issues latency-aligned write strobes and addresses to the processed buffer, and reports busy, done and frame-count status. It sits between `ov7670_capture`'s frame-end indication and the `frame_buffer` pair, and replaces the free-running address counter in the colour path.

## Interface
- `c_img_pxls`, 4800: pixels per frame (80x60).
- `c_nb_img_pxls`, 13: address width; must satisfy 2^c_nb_img_pxls >= c_img_pxls.
- `c_proc_lat`, 2: cycles from `orig_addr` to valid processed pixel (1 BRAM read + processing stages); range 1..8.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `enable`  in  1  allow new sweeps to start.
- `frame_done`  in  1  single-cycle pulse at the end of a captured frame.
- `orig_addr`  out  c_nb_img_pxls  read address to the original frame buffer.
- `proc_addr`  out  c_nb_img_pxls  write address to the processed frame buffer.
- `proc_we`  out  1  write strobe to the processed frame buffer.
- `busy`  out  1  high in SWEEP and DRAIN.
- `sweep_done`  out  1  one-cycle pulse after the last write of a sweep.
- `frame_cnt`  out  8  completed sweeps, modulo 256.

## Operation
- States: IDLE, SWEEP, DRAIN.
- IDLE: `orig_addr` is held at 0.
  - A trigger moves the block to SWEEP. A trigger is `frame_done`=1 with `enable`=1, or a set `pending` flag.
  - `frame_done` arriving while `enable`=0 is discarded.
- SWEEP: `orig_addr` increments by 1 each cycle, starting from 0.
  - A read-valid token enters a `c_proc_lat`-deep shift register together with its address.
  - When `orig_addr` = c_img_pxls-1, the next state is DRAIN and `orig_addr` returns to 0.
- DRAIN: no new tokens are issued. When the shift register is empty, the block:
  - pulses `sweep_done`,
  - increments `frame_cnt`,
  - returns to IDLE.
- Write side: `proc_we` and `proc_addr` are the output of the delay line. Each address 0..c_img_pxls-1 is written exactly once per completed sweep, in ascending order.
- `frame_done` during SWEEP or DRAIN: see Configuration.
- Deasserting `enable` mid-sweep does not abort; the sweep completes.
- `frame_cnt` wraps from 255 to 0.
- Reset, asynchronous at any time including mid-sweep:
  - state = IDLE, delay line cleared, `pending`=0,
  - all outputs 0 (`orig_addr`, `proc_addr`, `proc_we`, `busy`, `sweep_done`, `frame_cnt`).
  - A partial frame left in the processed buffer is accepted.

## Timing
- `frame_done` high in cycle t (IDLE, enabled):
  - `busy`=1 from t+1;
  - `orig_addr`=0 in t+1 and `orig_addr`=k in t+1+k;
  - `proc_we`=1 with `proc_addr`=k in t+1+k+c_proc_lat.
- Last write (`proc_addr`=c_img_pxls-1) occurs in cycle t+c_img_pxls+c_proc_lat.
- `sweep_done`=1 and `frame_cnt` is updated in cycle t+c_img_pxls+c_proc_lat+1; `busy` falls in the same cycle.
- Earliest next sweep: a trigger seen in the `sweep_done` cycle starts SWEEP in the following cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `COLOR_PROC_RESTART_EN` defined:
  - `frame_done` with `enable`=1 during SWEEP or DRAIN aborts the sweep.
  - The delay line is flushed (`proc_we` drops next cycle).
  - SWEEP restarts at address 0 in the next cycle.
  - No `sweep_done` pulse and no `frame_cnt` increment for the aborted sweep.
- Not defined:
  - Such a `frame_done` sets `pending`; repeated pulses collapse into one.
  - The current sweep completes normally.
  - The pending sweep starts in the cycle after `sweep_done`, with `pending` cleared on entry to SWEEP.

## Test plan
- Reset then single `frame_done` (`enable`=1, c_proc_lat=2):
  - `proc_we` first high exactly 3 cycles after the pulse, with `proc_addr`=0;
  - 4800 consecutive writes, addresses 0..4799;
  - `sweep_done` one cycle after address 4799;
  - `frame_cnt`=1.
- `frame_done` with `enable`=0:
  - no state change, `busy`=0, no writes.
  - Then `enable`=1 with a new pulse: the sweep runs normally.
- `frame_done` at `orig_addr`=1000:
  - without macro, the first sweep completes all 4800 writes, a second sweep starts the cycle after `sweep_done`, and `frame_cnt`=2 at the end;
  - with macro, `proc_we` drops, `orig_addr` goes to 0 next cycle, and `frame_cnt`=1 after the single completed sweep.
- Async `rst` pulse at `orig_addr`=2500: all outputs are 0 immediately, and a subsequent `frame_done` produces a full 4800-write sweep.
- 256 back-to-back sweeps: `frame_cnt` wraps to 0.
- c_proc_lat=1 and c_proc_lat=8: write timing matches the latency formula and `sweep_done` tracks it.

Source files
------------

// File: rtl/color_proc_sched.sv
// Frame-level scheduler: sweeps the original buffer's read port after each captured frame and
// issues latency-aligned writes to the processed buffer. Optional macro: COLOR_PROC_RESTART_EN.
module color_proc_sched #(
  parameter int c_img_pxls    = 4800,
  parameter int c_nb_img_pxls = 13,
  parameter int c_proc_lat    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     frame_done,
  output logic [c_nb_img_pxls-1:0] orig_addr,
  output logic [c_nb_img_pxls-1:0] proc_addr,
  output logic                     proc_we,
  output logic                     busy,
  output logic                     sweep_done,
  output logic [7:0]               frame_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

  localparam logic [c_nb_img_pxls-1:0] LAST_ADDR = c_nb_img_pxls'(c_img_pxls - 1);

  state_t                                    r_state;
  logic                                      r_pending;
  logic [c_nb_img_pxls-1:0]                  r_orig_addr;
  logic                                      r_busy;
  logic                                      r_sweep_done;
  logic [7:0]                                r_frame_cnt;
  logic [c_proc_lat-1:0]                     r_vld_pipe;
  logic [c_proc_lat-1:0][c_nb_img_pxls-1:0]  r_addr_pipe;

  logic                  w_start;
  logic                  w_fd_busy;
  logic [c_proc_lat-1:0] w_vld_sh;
  logic                  w_drain_empty;

  assign w_start   = (frame_done & enable) | r_pending;
  assign w_fd_busy = frame_done & enable & (r_state != S_IDLE);
  // Leave DRAIN when the pipe will be empty after this shift, so sweep_done
  // lands the cycle right after the final write.
  assign w_vld_sh      = r_vld_pipe << 1;
  assign w_drain_empty = (w_vld_sh == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pending    <= 1'b0;
      r_orig_addr  <= '0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_vld_pipe   <= '0;
      r_addr_pipe  <= '0;
    end else begin
      r_sweep_done   <= 1'b0;
      r_vld_pipe[0]  <= (r_state == S_SWEEP);
      r_addr_pipe[0] <= r_orig_addr;
      for (int i = 1; i < c_proc_lat; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_addr_pipe[i] <= r_addr_pipe[i-1];
      end
      case (r_state)
        S_IDLE: begin
          r_orig_addr <= '0;
          if (w_start) begin
            r_state   <= S_SWEEP;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (r_orig_addr == LAST_ADDR) begin
            r_state     <= S_DRAIN;
            r_orig_addr <= '0;
          end else begin
            r_orig_addr <= r_orig_addr + c_nb_img_pxls'(1);
          end
        end
        S_DRAIN: begin
          if (w_drain_empty) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef COLOR_PROC_RESTART_EN
      // Abort overrides everything above, including a completing drain.
      if (w_fd_busy) begin
        r_state      <= S_SWEEP;
        r_orig_addr  <= '0;
        r_vld_pipe   <= '0;
        r_busy       <= 1'b1;
        r_sweep_done <= 1'b0;
        r_frame_cnt  <= r_frame_cnt;
      end
`else
      if (w_fd_busy) r_pending <= 1'b1;
`endif
    end
  end

  assign orig_addr  = r_orig_addr;
  assign proc_addr  = r_addr_pipe[c_proc_lat-1];
  assign proc_we    = r_vld_pipe[c_proc_lat-1];
  assign busy       = r_busy;
  assign sweep_done = r_sweep_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_color_proc_sched.sv
// Scoreboard bench for color_proc_sched: a full-size instance (latency 2) plus
// two 16-pixel instances at latency 1 and 8 for wrap and latency checks.
module tb_color_proc_sched;
  localparam int N  = 4800;
  localparam int L  = 2;
  localparam int NS = 16;

  typedef struct {int addr; int cyc;} wr_t;
  typedef struct {int cyc; int cnt;} sd_t;

  logic        clk, rst, enable, frame_done, fd_l1, fd_l8;
  logic [12:0] orig_addr, proc_addr;
  logic        proc_we, busy, sweep_done;
  logic [7:0]  frame_cnt;
  logic [3:0]  oa_l1, pa_l1, oa_l8, pa_l8;
  logic        we_l1, bz_l1, sd_l1, we_l8, bz_l8, sd_l8;
  logic [7:0]  cnt_l1, cnt_l8;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  wr_t  wq[$];
  sd_t  sdq[$];
  wr_t  mon_w;
  sd_t  mon_s;

  color_proc_sched #(.c_img_pxls(N), .c_nb_img_pxls(13), .c_proc_lat(L)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_done(frame_done),
    .orig_addr(orig_addr), .proc_addr(proc_addr), .proc_we(proc_we),
    .busy(busy), .sweep_done(sweep_done), .frame_cnt(frame_cnt));

  color_proc_sched #(.c_img_pxls(NS), .c_nb_img_pxls(4), .c_proc_lat(1)) dut_l1 (
    .clk(clk), .rst(rst), .enable(enable), .frame_done(fd_l1),
    .orig_addr(oa_l1), .proc_addr(pa_l1), .proc_we(we_l1),
    .busy(bz_l1), .sweep_done(sd_l1), .frame_cnt(cnt_l1));

  color_proc_sched #(.c_img_pxls(NS), .c_nb_img_pxls(4), .c_proc_lat(8)) dut_l8 (
    .clk(clk), .rst(rst), .enable(enable), .frame_done(fd_l8),
    .orig_addr(oa_l8), .proc_addr(pa_l8), .proc_we(we_l8),
    .busy(bz_l8), .sweep_done(sd_l8), .frame_cnt(cnt_l8));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write and sweep_done scoreboard for the full-size instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (proc_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected addr=%0d cyc=%0d", proc_addr, cyc);
        end else begin
          mon_w = wq.pop_front();
          if (proc_addr !== 13'(mon_w.addr) || cyc !== mon_w.cyc) begin
            errors++;
            $display("FAIL wr addr=%0d cyc=%0d want addr=%0d cyc=%0d", proc_addr, cyc, mon_w.addr, mon_w.cyc);
          end
        end
      end
      if (sweep_done) begin
        checks++;
        if (sdq.size() == 0) begin
          errors++;
          $display("FAIL sd_unexpected cyc=%0d", cyc);
        end else begin
          mon_s = sdq.pop_front();
          if (cyc !== mon_s.cyc || frame_cnt !== 8'(mon_s.cnt) || busy !== 1'b0) begin
            errors++;
            $display("FAIL sd cyc=%0d cnt=%0d busy=%b want cyc=%0d cnt=%0d busy=0",
                     cyc, frame_cnt, busy, mon_s.cyc, mon_s.cnt);
          end
        end
      end
    end
  end

  // Expectations for a sweep whose trigger is seen in cycle t.
  task automatic start_sweep(input int t);
    sd_t s;
    for (int k = 0; k < N; k++) wq.push_back('{addr: k, cyc: t + 1 + k + L});
    exp_cnt++;
    s.cyc = t + N + L + 1;
    s.cnt = exp_cnt % 256;
    sdq.push_back(s);
  endtask

  task automatic pulse_now(output int t);
    frame_done = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    frame_done = 1'b0;
  endtask

  task automatic pulse(output int t);
    @(posedge clk); #1;
    pulse_now(t);
  endtask

  task automatic wait_addr(input int a);
    int k;
    for (k = 0; k < 2 * N; k++) begin
      @(posedge clk); #1;
      if (orig_addr == 13'(a)) break;
    end
    checks++;
    if (k == 2 * N) begin
      errors++;
      $display("FAIL wait_addr timeout got=%0d want=%0d", orig_addr, a);
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 3 * N && (wq.size() != 0 || sdq.size() != 0); k++) @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (wq.size() != 0 || sdq.size() != 0 || busy !== 1'b0 || proc_we !== 1'b0) begin
      errors++;
      $display("FAIL drain wq=%0d sdq=%0d busy=%b we=%b want 0 0 0 0", wq.size(), sdq.size(), busy, proc_we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; frame_done = 1'b0; fd_l1 = 1'b0; fd_l8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({orig_addr, proc_addr, proc_we, busy, sweep_done, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset oa=%0d pa=%0d we=%b busy=%b sd=%b cnt=%0d want all 0",
               orig_addr, proc_addr, proc_we, busy, sweep_done, frame_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int t;
    enable = 1'b1;
    pulse(t);
    start_sweep(t);
    checks++;
    if (busy !== 1'b1 || orig_addr !== 13'd0) begin
      errors++;
      $display("FAIL single_start busy=%b oa=%0d want 1 0", busy, orig_addr);
    end
    drain();
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_cnt got=%0d want=1", frame_cnt);
    end
  endtask

  task automatic test_disabled();
    int t;
    enable = 1'b0;
    pulse(t);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (busy !== 1'b0 || proc_we !== 1'b0 || orig_addr !== 13'd0) begin
        errors++;
        $display("FAIL disabled busy=%b we=%b oa=%0d want 0 0 0", busy, proc_we, orig_addr);
      end
      @(posedge clk); #1;
    end
    enable = 1'b1;
    pulse(t);
    start_sweep(t);
    drain();
    checks++;
    if (frame_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL disabled_cnt got=%0d want=%0d", frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_mid_frame();
    int t, c;
    pulse(t);
    start_sweep(t);
    wait_addr(1000);
    pulse_now(c);
`ifdef COLOR_PROC_RESTART_EN
    while (wq.size() != 0 && wq[$].cyc > c) void'(wq.pop_back());
    void'(sdq.pop_back());
    exp_cnt--;
    start_sweep(c);
    checks++;
    if (proc_we !== 1'b0 || orig_addr !== 13'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart we=%b oa=%0d busy=%b want 0 0 1", proc_we, orig_addr, busy);
    end
`else
    start_sweep(t + N + L + 1);
    checks++;
    if (busy !== 1'b1 || orig_addr !== 13'd1001) begin
      errors++;
      $display("FAIL pending_cont busy=%b oa=%0d want 1 1001", busy, orig_addr);
    end
`endif
    drain();
    checks++;
    if (frame_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL mid_cnt got=%0d want=%0d", frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int prev, k;
    @(posedge clk); #1;
    fd_l1 = 1'b1; prev = cyc;
    @(posedge clk); #1;
    fd_l1 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (k = 0; k < 100 && !sd_l1; k++) begin
        @(posedge clk); #1;
      end
      checks++;
      if (!sd_l1 || cyc - prev != NS + 1 + 1 || cnt_l1 !== 8'(i + 1)) begin
        errors++;
        $display("FAIL b2b sweep=%0d sd=%b gap=%0d cnt=%0d want 1 %0d %0d", i, sd_l1, cyc - prev, cnt_l1, NS + 2, (i + 1) % 256);
        return;
      end
      if (i < 255) begin
        fd_l1 = 1'b1; prev = cyc;
      end
      @(posedge clk); #1;
      fd_l1 = 1'b0;
    end
    checks++;
    if (cnt_l1 !== 8'd0 || bz_l1 !== 1'b0) begin
      errors++;
      $display("FAIL wrap cnt=%0d busy=%b want 0 0", cnt_l1, bz_l1);
    end
  endtask

  task automatic test_latency();
    int t, lat;
    logic we, sd, exp_we, exp_sd;
    logic [3:0] ad;
    logic [7:0] cnt;
    for (int p = 0; p < 2; p++) begin
      lat = (p == 0) ? 1 : 8;
      @(posedge clk); #1;
      if (p == 0) fd_l1 = 1'b1; else fd_l8 = 1'b1;
      t = cyc;
      @(posedge clk); #1;
      fd_l1 = 1'b0; fd_l8 = 1'b0;
      for (int c = t + 1; c <= t + NS + lat + 4; c++) begin
        we = (p == 0) ? we_l1 : we_l8;
        ad = (p == 0) ? pa_l1 : pa_l8;
        sd = (p == 0) ? sd_l1 : sd_l8;
        exp_we = (c >= t + 1 + lat) && (c <= t + NS + lat);
        exp_sd = (c == t + NS + lat + 1);
        checks++;
        if (we !== exp_we || (exp_we && ad !== 4'(c - t - 1 - lat)) || sd !== exp_sd) begin
          errors++;
          $display("FAIL lat%0d cyc=+%0d we=%b addr=%0d sd=%b want %b %0d %b",
                   lat, c - t, we, ad, sd, exp_we, 4'(c - t - 1 - lat), exp_sd);
        end
        @(posedge clk); #1;
      end
      cnt = (p == 0) ? cnt_l1 : cnt_l8;
      checks++;
      if (cnt !== 8'd1) begin
        errors++;
        $display("FAIL lat%0d_cnt got=%0d want=1", lat, cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    int t;
    pulse(t);
    start_sweep(t);
    wait_addr(2500);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({orig_addr, proc_addr, proc_we, busy, sweep_done, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL async_rst oa=%0d pa=%0d we=%b busy=%b sd=%b cnt=%0d want all 0",
               orig_addr, proc_addr, proc_we, busy, sweep_done, frame_cnt);
    end
    wq.delete();
    sdq.delete();
    exp_cnt = 0;
    rst = 1'b0;
    pulse(t);
    start_sweep(t);
    drain();
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL async_rst_cnt got=%0d want=1", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_disabled();
    test_mid_frame();
    test_back_to_back();
    test_latency();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
